// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issue-side companion to the 12-bit fixed-point ALU.
// Commands are queued in a FIFO and issued as unbroken bursts (head through the
// first closing entry). A MAC burst is followed by one idle cycle with opcode
// 000 so the ALU accumulator is cleared before the next chain. ALU results are
// queued and returned over a valid/ready handshake; overflow is tracked per
// result and as a sticky flag.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 8,
  parameter int RDEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] s_data_a,
  input  logic [11:0] s_data_b,
  input  logic [2:0]  s_inst,
  input  logic        s_last,
  output logic        alu_valid,
  output logic [11:0] alu_data_a,
  output logic [11:0] alu_data_b,
  output logic [2:0]  alu_inst,
  input  logic        alu_o_valid,
  input  logic [11:0] alu_o_data,
  input  logic        alu_o_overflow,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [11:0] m_data,
  output logic        m_overflow,
  output logic        o_split,
  output logic        o_ovf_sticky,
  input  logic        i_clr_sticky
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int RAW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int RCW = $clog2(RDEPTH + 1);
  localparam int SW  = RCW + 1;

  localparam logic [2:0] OP_MAC = 3'b011;
  localparam logic [2:0] OP_NOP = 3'b000;

  typedef struct packed {
    logic        close;
    logic [2:0]  inst;
    logic [11:0] a;
    logic [11:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Command FIFO storage and bookkeeping
  cmd_t            cmem [DEPTH];
  logic [AW-1:0]   cwr_ptr_q, crd_ptr_q;
  logic [CW-1:0]   ccount_q, ccount_d;
  logic [CW-1:0]   closer_cnt_q, closer_cnt_d;
  logic            s_ready_q, s_ready_d;
  logic            push_s, in_close_s, fill_s;
  cmd_t            push_entry_s, head_s;

  // Issue FSM
  state_t          state_q, state_d;
  logic            issue_s, go_s, credit_ok_s;
  logic            inflight_q;
  logic [SW-1:0]   need_s;

  // Result FIFO
  logic [12:0]     rmem [RDEPTH];
  logic [RAW-1:0]  rwr_ptr_q, rrd_ptr_q;
  logic [RCW-1:0]  rcount_q, rcount_d;
  logic            rpush_s, rpop_s, rvalid_s;
  logic            sticky_q, sticky_d;

  assign head_s = cmem[crd_ptr_q];

  // Command acceptance: closer marking and forced split of an unterminated chain
  always_comb begin
    push_s       = s_valid & s_ready_q;
    in_close_s   = (s_inst != OP_MAC) | s_last;
    fill_s       = push_s & (ccount_q == CW'(DEPTH - 1)) &
                   (closer_cnt_q == '0) & ~in_close_s;
    push_entry_s = {in_close_s | fill_s, s_inst, s_data_a, s_data_b};
  end

  // Command FIFO occupancy and closer-count next state
  always_comb begin
    ccount_d     = ccount_q;
    closer_cnt_d = closer_cnt_q;
    if (push_s && !issue_s) begin
      ccount_d = ccount_q + CW'(1);
    end else if (!push_s && issue_s) begin
      ccount_d = ccount_q - CW'(1);
    end else begin
      ccount_d = ccount_q;
    end
    if ((push_s && push_entry_s.close) && !(issue_s && head_s.close)) begin
      closer_cnt_d = closer_cnt_q + CW'(1);
    end else if (!(push_s && push_entry_s.close) && (issue_s && head_s.close)) begin
      closer_cnt_d = closer_cnt_q - CW'(1);
    end else begin
      closer_cnt_d = closer_cnt_q;
    end
    s_ready_d = (ccount_d != CW'(DEPTH));
  end

  // Conservative credit check: every queued command must fit in the result FIFO
  always_comb begin
    need_s      = SW'(rcount_q) + SW'(inflight_q) + SW'(ccount_q);
    credit_ok_s = (need_s <= SW'(RDEPTH));
    go_s        = (closer_cnt_q != '0) & credit_ok_s;
  end

  // Issue FSM next state; the first entry of a burst issues in the deciding cycle
  always_comb begin
    state_d = state_q;
    issue_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        issue_s = 1'b1;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (issue_s) begin
      if (!head_s.close) begin
        state_d = ST_ISSUE;
      end else if (head_s.inst == OP_MAC) begin
        state_d = ST_GAP;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_d;
    end
  end

  // Result FIFO push/pop and sticky overflow next state
  always_comb begin
    rvalid_s = (rcount_q != '0);
    rpop_s   = rvalid_s & m_ready;
    rpush_s  = alu_o_valid & ((rcount_q != RCW'(RDEPTH)) | rpop_s);
    rcount_d = rcount_q;
    if (rpush_s && !rpop_s) begin
      rcount_d = rcount_q + RCW'(1);
    end else if (!rpush_s && rpop_s) begin
      rcount_d = rcount_q - RCW'(1);
    end else begin
      rcount_d = rcount_q;
    end
    if (i_clr_sticky) begin
      sticky_d = 1'b0;
    end else if (rpush_s && alu_o_overflow) begin
      sticky_d = 1'b1;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Command FIFO storage write (data only, no reset needed)
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      cmem[cwr_ptr_q] <= push_entry_s;
    end
  end

  // Result FIFO storage write (data only, no reset needed)
  always_ff @(posedge i_clk) begin
    if (rpush_s) begin
      rmem[rwr_ptr_q] <= {alu_o_overflow, alu_o_data};
    end
  end

  // Control state: pointers, counts, FSM, in-flight marker, sticky flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cwr_ptr_q    <= '0;
      crd_ptr_q    <= '0;
      ccount_q     <= '0;
      closer_cnt_q <= '0;
      s_ready_q    <= 1'b0;
      state_q      <= ST_IDLE;
      inflight_q   <= 1'b0;
      rwr_ptr_q    <= '0;
      rrd_ptr_q    <= '0;
      rcount_q     <= '0;
      sticky_q     <= 1'b0;
    end else begin
      if (push_s) cwr_ptr_q <= cwr_ptr_q + AW'(1);
      if (issue_s) crd_ptr_q <= crd_ptr_q + AW'(1);
      ccount_q     <= ccount_d;
      closer_cnt_q <= closer_cnt_d;
      s_ready_q    <= s_ready_d;
      state_q      <= state_d;
      inflight_q   <= issue_s;
      if (rpush_s) rwr_ptr_q <= (rwr_ptr_q == RAW'(RDEPTH - 1)) ? '0 : rwr_ptr_q + RAW'(1);
      if (rpop_s) rrd_ptr_q <= (rrd_ptr_q == RAW'(RDEPTH - 1)) ? '0 : rrd_ptr_q + RAW'(1);
      rcount_q     <= rcount_d;
      sticky_q     <= sticky_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign o_split      = fill_s;
  assign alu_valid    = issue_s;
  assign alu_inst     = issue_s ? head_s.inst : OP_NOP;
  assign alu_data_a   = issue_s ? head_s.a : 12'd0;
  assign alu_data_b   = issue_s ? head_s.b : 12'd0;
  assign m_valid      = rvalid_s;
  assign m_data       = rvalid_s ? rmem[rrd_ptr_q][11:0] : 12'd0;
  assign m_overflow   = rvalid_s ? rmem[rrd_ptr_q][12] : 1'b0;
  assign o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: behavioural ALU, chain-level reference
// model feeding a scoreboard queue, and a decoupled result monitor.
module tb_alu_cmd_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        s_valid, s_ready, s_last;
  logic [11:0] s_data_a, s_data_b;
  logic [2:0]  s_inst;
  logic        alu_valid;
  logic [11:0] alu_data_a, alu_data_b;
  logic [2:0]  alu_inst;
  logic        alu_o_valid, alu_o_overflow;
  logic [11:0] alu_o_data;
  logic        m_valid, m_ready, m_overflow;
  logic [11:0] m_data;
  logic        o_split, o_ovf_sticky, i_clr_sticky;

  logic        m_ready_dir, rnd_mready;
  bit          rand_mode;
  assign m_ready = rand_mode ? rnd_mready : m_ready_dir;

  int tests = 0;
  int fails = 0;

  alu_cmd_sequencer #(.DEPTH(8), .RDEPTH(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_a(s_data_a), .s_data_b(s_data_b),
    .s_inst(s_inst), .s_last(s_last),
    .alu_valid(alu_valid), .alu_data_a(alu_data_a), .alu_data_b(alu_data_b), .alu_inst(alu_inst),
    .alu_o_valid(alu_o_valid), .alu_o_data(alu_o_data), .alu_o_overflow(alu_o_overflow),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_overflow(m_overflow),
    .o_split(o_split), .o_ovf_sticky(o_ovf_sticky), .i_clr_sticky(i_clr_sticky)
  );

  always #5 i_clk = ~i_clk;

  // Fixed-point ALU arithmetic: returns {overflow, result}
  function automatic logic [12:0] alu_calc(input logic [2:0] inst, input logic [11:0] a,
                                           input logic [11:0] b, input logic [11:0] acc);
    int sa, sb, sc, w;
    logic [11:0] lo;
    sa = $signed(a); sb = $signed(b); sc = $signed(acc);
    case (inst)
      3'd0: w = sa + sb;
      3'd1: w = sa - sb;
      3'd2: w = (sa * sb) >>> 5;
      3'd3: w = sc + ((sa * sb) >>> 5);
      default: begin
        lo = a & b;
        return {1'b0, lo};
      end
    endcase
    lo = w[11:0];
    return {(w > 2047) || (w < -2048), lo};
  endfunction

  // Behavioural ALU: 1-cycle registered result; idle opcode 000 clears the accumulator
  logic [11:0] acc_env;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_o_valid <= 1'b0; alu_o_data <= 12'd0; alu_o_overflow <= 1'b0; acc_env <= 12'd0;
    end else begin
      alu_o_valid <= alu_valid;
      if (alu_valid) begin
        {alu_o_overflow, alu_o_data} <= alu_calc(alu_inst, alu_data_a, alu_data_b, acc_env);
        if (alu_inst == 3'd3) acc_env <= alu_calc(alu_inst, alu_data_a, alu_data_b, acc_env);
      end else if (alu_inst == 3'd0) begin
        acc_env <= 12'd0;
      end
    end
  end

  // Reference model: results in command order, MAC chains accumulate until a closer
  logic [12:0] exp_q[$];
  logic [11:0] ref_acc = 12'd0;
  bit          ref_sticky = 1'b0;

  task automatic model_push(input logic [2:0] inst, input logic [11:0] a, b, input bit close);
    logic [12:0] r;
    r = alu_calc(inst, a, b, (inst == 3'd3) ? ref_acc : 12'd0);
    if (inst == 3'd3 && !close) ref_acc = r[11:0];
    else ref_acc = 12'd0;
    ref_sticky = ref_sticky | r[12];
    exp_q.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic push(input logic [2:0] inst, input logic [11:0] a, b, input logic last,
                      input bit force_close, output logic split);
    int n;
    s_valid = 1'b1; s_inst = inst; s_data_a = a; s_data_b = b; s_last = last;
    #1;
    n = 0;
    while (!s_ready && n < 300) begin tick(); n++; end
    chk("push_ready", {31'd0, s_ready}, 32'd1);
    split = o_split;
    if (s_ready) begin
      model_push(inst, a, b, (inst != 3'd3) || last || force_close);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin tick(); n++; end
    chk("drain", exp_q.size(), 32'd0);
    repeat (3) tick();
  endtask

  // Result monitor: pop scoreboard on each handshake, check hold-while-stalled
  logic        stalled_prev = 1'b0;
  logic [12:0] held;
  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (m_valid && stalled_prev) chk("m_hold", {19'd0, m_overflow, m_data}, {19'd0, held});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("m_unexpected", {31'd0, m_valid}, 32'd0);
        else chk("m_result", {19'd0, m_overflow, m_data}, {19'd0, exp_q.pop_front()});
      end
      stalled_prev = m_valid && !m_ready;
      held = {m_overflow, m_data};
    end
  end

  // ALU issue trace and pulse counter for burst-shape checks
  logic [3:0] trace[$];
  bit tracing = 1'b0, counting = 1'b0;
  int alu_cnt = 0, mval_cnt = 0;
  initial forever begin
    @(negedge i_clk);
    if (tracing) trace.push_back({alu_valid, alu_inst});
    if (counting && alu_valid) alu_cnt++;
    if (counting && m_valid) mval_cnt++;
  end

  // Random downstream backpressure
  initial forever begin
    @(posedge i_clk); #1;
    rnd_mready = ($urandom_range(0, 3) != 0);
  end

  function automatic int first_valid();
    for (int i = 0; i < trace.size(); i++) if (trace[i][3]) return i;
    return trace.size();
  endfunction

  task automatic chk_tr(input string name, input int idx, input logic [3:0] exp);
    if (idx < trace.size()) chk(name, {28'd0, trace[idx]}, {28'd0, exp});
    else chk({name, "_len"}, trace.size(), idx + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] ops [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    logic sp;
    int f, nsplit, len;
    i_rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_inst = 3'd0;
    s_data_a = 12'd0; s_data_b = 12'd0; i_clr_sticky = 1'b0;
    m_ready_dir = 1'b1; rand_mode = 1'b0;
    #2;
    chk("reset_outs", {s_ready, alu_valid, alu_data_a, alu_data_b, alu_inst, m_valid, m_data,
                       m_overflow, o_split, o_ovf_sticky}, 32'd0);
    repeat (3) tick();
    i_rst_n = 1'b1; #1;
    chk("ready_pre", {31'd0, s_ready}, 32'd0);
    tick();
    chk("ready_post", {31'd0, s_ready}, 32'd1);

    // Single ADD latency
    push(3'd0, 12'h010, 12'h005, 1'b0, 1'b0, sp);
    chk("add_alu_valid", {28'd0, alu_valid, alu_inst}, 32'h8);
    tick();
    chk("add_m_early", {31'd0, m_valid}, 32'd0);
    tick();
    chk("add_m_valid", {19'd0, m_valid, m_overflow, m_data}, {19'd0, 2'b10, 12'h015});
    wait_drain();

    // MAC chain of 3 followed by ADD
    trace.delete(); tracing = 1'b1;
    push(3'd3, 12'h020, 12'h020, 1'b0, 1'b0, sp);
    push(3'd3, 12'h020, 12'h020, 1'b0, 1'b0, sp);
    push(3'd3, 12'h020, 12'h020, 1'b1, 1'b0, sp);
    push(3'd0, 12'h001, 12'h002, 1'b0, 1'b0, sp);
    repeat (10) tick();
    tracing = 1'b0;
    f = first_valid();
    for (int i = 0; i < 3; i++) chk_tr("mac3_burst", f + i, 4'b1011);
    chk_tr("mac3_gap", f + 3, 4'b0000);
    chk_tr("mac3_add", f + 4, 4'b1000);
    wait_drain();

    // Two MAC chains of 2: exactly one idle cycle between
    trace.delete(); tracing = 1'b1;
    for (int i = 0; i < 4; i++) push(3'd3, 12'h020, 12'h020, (i % 2) == 1, 1'b0, sp);
    repeat (10) tick();
    tracing = 1'b0;
    f = first_valid();
    chk_tr("mac2_a0", f, 4'b1011);
    chk_tr("mac2_a1", f + 1, 4'b1011);
    chk_tr("mac2_gap", f + 2, 4'b0000);
    chk_tr("mac2_b0", f + 3, 4'b1011);
    chk_tr("mac2_b1", f + 4, 4'b1011);
    chk_tr("mac2_gap2", f + 5, 4'b0000);
    wait_drain();

    // Eight unterminated MACs force a split
    trace.delete(); tracing = 1'b1; nsplit = 0;
    for (int i = 0; i < 7; i++) begin
      push(3'd3, 12'h020, 12'h020, 1'b0, 1'b0, sp);
      nsplit += int'(sp);
    end
    chk("split_early", nsplit, 32'd0);
    push(3'd3, 12'h020, 12'h020, 1'b0, 1'b1, sp);
    chk("split_pulse", {31'd0, sp}, 32'd1);
    chk("full_ready", {31'd0, s_ready}, 32'd0);
    chk("split_clear", {31'd0, o_split}, 32'd0);
    repeat (14) tick();
    tracing = 1'b0;
    f = first_valid();
    for (int i = 0; i < 8; i++) chk_tr("split_burst", f + i, 4'b1011);
    chk_tr("split_gap", f + 8, 4'b0000);
    wait_drain();

    // Result FIFO backpressure: issue stops at RDEPTH, nothing lost
    m_ready_dir = 1'b0; alu_cnt = 0; counting = 1'b1;
    for (int i = 0; i < 10; i++) push(3'd0, 12'($urandom_range(0, 255)), 12'(i), 1'b0, 1'b0, sp);
    repeat (20) tick();
    chk("stall_issued", alu_cnt, 32'd8);
    chk("stall_m_valid", {31'd0, m_valid}, 32'd1);
    m_ready_dir = 1'b1;
    wait_drain();
    chk("stall_all_issued", alu_cnt, 32'd10);
    counting = 1'b0;

    // Overflow and sticky flag
    push(3'd0, 12'h7FF, 12'h001, 1'b0, 1'b0, sp);
    wait_drain();
    chk("sticky_set", {31'd0, o_ovf_sticky}, 32'd1);
    i_clr_sticky = 1'b1; tick(); i_clr_sticky = 1'b0;
    chk("sticky_clr", {31'd0, o_ovf_sticky}, 32'd0);
    i_clr_sticky = 1'b1;
    push(3'd0, 12'h7FF, 12'h7FF, 1'b0, 1'b0, sp);
    wait_drain();
    chk("sticky_clr_wins", {31'd0, o_ovf_sticky}, 32'd0);
    i_clr_sticky = 1'b0; ref_sticky = 1'b0;

    // Randomized traffic with random backpressure
    rand_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++)
          push(3'd3, 12'($urandom), 12'($urandom), k == len - 1, 1'b0, sp);
      end else begin
        push(ops[$urandom_range(0, 6)], 12'($urandom), 12'($urandom), $urandom_range(0, 1) == 1,
             1'b0, sp);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_mode = 1'b0;
    wait_drain();
    chk("sticky_random", {31'd0, o_ovf_sticky}, {31'd0, ref_sticky});

    // Reset in the middle of a burst
    m_ready_dir = 1'b0;
    for (int i = 0; i < 6; i++) push(3'd3, 12'h020, 12'h010, i == 5, 1'b0, sp);
    for (int i = 0; i < 2; i++) push(3'd0, 12'h003, 12'h004, 1'b0, 1'b0, sp);
    f = 0;
    while (!alu_valid && f < 50) begin tick(); f++; end
    chk("rst_burst_started", {31'd0, alu_valid}, 32'd1);
    tick();
    i_rst_n = 1'b0; #1;
    chk("rst_outs", {s_ready, alu_valid, alu_data_a, alu_data_b, alu_inst, m_valid, m_data,
                     m_overflow, o_split, o_ovf_sticky}, 32'd0);
    exp_q.delete(); ref_acc = 12'd0;
    m_ready_dir = 1'b1;
    repeat (2) tick();
    i_rst_n = 1'b1;
    mval_cnt = 0; alu_cnt = 0; counting = 1'b1;
    repeat (15) tick();
    counting = 1'b0;
    chk("rst_no_m_valid", mval_cnt, 32'd0);
    chk("rst_no_issue", alu_cnt, 32'd0);
    chk("rst_ready", {31'd0, s_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Issue-side companion to the 12-bit fixed-point ALU; owns the ALU input port (valid, operands, opcode) and consumes its registered result port (1-cycle latency, no backpressure).
- Buffers upstream commands in a FIFO and issues MAC chains as unbroken back-to-back bursts, so the ALU accumulator is never corrupted by bubbles or stale state.
- Buffers ALU results and returns them downstream over a valid/ready handshake.
- Tracks overflow per result and as a sticky flag.

Parameters:
- DEPTH, 8: command FIFO entries, power of 2, ≥2.
- RDEPTH, 8: result FIFO entries, ≥ DEPTH.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- s_valid  in  1  command valid
- s_ready  out  1  command FIFO not full
- s_data_a  in  12  operand A, signed Q6.5 for MUL/MAC
- s_data_b  in  12  operand B
- s_inst  in  3  opcode; 011 = MAC
- s_last  in  1  closes a MAC chain; ignored for non-MAC
- alu_valid  out  1  ALU issue strobe
- alu_data_a  out  12  to ALU
- alu_data_b  out  12  to ALU
- alu_inst  out  3  to ALU
- alu_o_valid  in  1  ALU result valid
- alu_o_data  in  12  ALU result
- alu_o_overflow  in  1  ALU overflow
- m_valid  out  1  result valid
- m_ready  in  1  downstream accept
- m_data  out  12  result
- m_overflow  out  1  overflow for this result
- o_split  out  1  1-cycle pulse: MAC chain force-closed
- o_ovf_sticky  out  1  OR of all overflows since reset or clear
- i_clr_sticky  in  1  synchronous clear of o_ovf_sticky

Behaviour:

Reset (async, i_rst_n=0):
- Both FIFOs emptied; state IDLE.
- All outputs 0: s_ready, alu_valid, alu_data_a/b, alu_inst, m_valid, m_data, m_overflow, o_split, o_ovf_sticky.
- s_ready rises the first cycle after deassertion.
- Reset mid-burst drops every queued and in-flight command and result; no partial output.

Command acceptance and closers:
- Accept on s_valid & s_ready. Stored entry is {close, inst, a, b}.
- close = 1 if inst != 011, or s_last = 1.
- If an entry fills the FIFO while the FIFO holds no closer, its close bit is forced to 1 and o_split pulses that cycle. This prevents deadlock on an unterminated chain.
- Burst = head entry through the first entry with close = 1, inclusive.

Issue FSM:
- IDLE:
  - alu_valid = 0, alu_inst = 000.
  - Move to ISSUE when: closer count > 0, AND free ≥ command FIFO count.
  - free = RDEPTH − result count − in-flight (0/1). This is a conservative credit check.
- ISSUE:
  - Pop the head every cycle; drive alu_valid = 1 and the entry fields.
  - Issue uninterrupted until the closer pops. No mid-burst credit recheck.
  - After the closer: if closer inst = 011, go to GAP; else go to IDLE.
- GAP:
  - One cycle with alu_valid = 0 and alu_inst = 000, which clears the ALU accumulator.
  - Then go to IDLE.
  - Guarantees two consecutive MAC chains never accumulate into each other.
- The IDLE→ISSUE decision uses registered counts. Command issued in cycle N (alu_valid high in N) → alu_o_valid in N+1.

Results:
- Write to the result FIFO on every alu_o_valid.
- Head is presented as m_valid / m_data / m_overflow; pop on m_valid & m_ready.
- m_* must hold stable while m_valid & !m_ready.
- Latency: accept in cycle 0 → alu_valid cycle 1 → alu_o_valid cycle 2 → m_valid cycle 3, for an empty pipeline with a closing command.

Flags and simultaneous events:
- o_ovf_sticky sets on any written result with overflow = 1.
- i_clr_sticky wins over a same-cycle set.
- Simultaneous push and pop on a full FIFO is allowed for the result FIFO only. s_ready is low when the command FIFO is full.
- Count and pointer wrap-around: modulo depth.

Test Plan:
- Single ADD a=12'h010, b=12'h005 → alu_valid cycle 1 with inst 000; m_valid cycle 3, m_data=12'h015, m_overflow=0.
- MAC chain (a=b=12'h020, i.e. 1.0) ×3, last on third, then ADD → three consecutive alu_valid cycles with inst 011 and no gaps; results 12'h020, 12'h040, 12'h060; ADD issued only after a GAP cycle with alu_inst=000.
- Two MAC chains of 2, both closed by s_last → exactly one idle cycle between the bursts; second chain restarts at 12'h020.
- 8 MACs, none with s_last, DEPTH=8 → o_split pulses on the 8th accept; burst of 8 issues; s_ready low while full.
- m_ready=0 with 10 commands queued → issue stops once result FIFO reaches RDEPTH; no result lost; all 10 delivered in order once m_ready=1.
- ADD 12'h7FF + 12'h001 → m_overflow=1, o_ovf_sticky=1; i_clr_sticky pulse → 0; assert i_rst_n=0 mid-burst → all outputs 0 immediately; no stale m_valid after release.
